ev22_writeback_stage: RTL and testbench

//  Final pipeline stage of the EV22 core. Sits directly upstream of the destination

---
 rtl/ev22_writeback_stage_if.sv | 28 ++
 rtl/ev22_writeback_stage.sv | 115 +++++++++++
 tb/tb_ev22_writeback_stage.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ev22_writeback_stage_if.sv
// Upstream issue handshake and data-memory read bus of the EV22 writeback stage.
// The stage is the slave; the surrounding pipeline and memory form the master side.
interface ev22_writeback_stage_if #(
  parameter int DW = 16,
  parameter int AW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [5:0]    in_dest;
  logic [DW-1:0] in_result;
  logic          in_is_load;
  logic [AW-1:0] in_addr;

  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport master (
    output in_valid, in_dest, in_result, in_is_load, in_addr, mem_rdata, mem_ack,
    input  in_ready, mem_req, mem_addr
  );

  modport slave (
    input  in_valid, in_dest, in_result, in_is_load, in_addr, mem_rdata, mem_ack,
    output in_ready, mem_req, mem_addr
  );
endinterface

// File: rtl/ev22_writeback_stage.sv
// EV22 writeback stage: registers ALU results, performs loads against data memory with
// a bounded wait, and presents one destination-select/data beat per retired instruction.
module ev22_writeback_stage #(
  parameter int DW          = 16,
  parameter int AW          = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ev22_writeback_stage_if.slave   bus,
  output logic [5:0]              C,
  output logic [DW-1:0]           busC,
  output logic [DW-1:0]           memory,
  output logic                    mem_err,
  output logic [15:0]             retire_cnt
);

  localparam int         CW        = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [5:0] DEST_LOAD = 6'd62;
  localparam logic [5:0] DEST_NONE = 6'd63;

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, COMMIT} state_t;

  state_t        state_q, state_d;
  logic [5:0]    c_d;
  logic [DW-1:0] busc_d, memory_d;
  logic          mem_err_d;
  logic [15:0]   retire_d;
  logic          mem_req_q, mem_req_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          transfer;

  assign bus.in_ready = (state_q != LOAD_WAIT);
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;
  assign transfer     = bus.in_valid && bus.in_ready;

  // NOTE: every signal gets a default before the case so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    c_d        = DEST_NONE;
    busc_d     = busC;
    memory_d   = memory;
    mem_err_d  = 1'b0;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    wait_d     = wait_q;
    retire_d   = retire_cnt;

    // Every cycle spent in COMMIT is one retirement, including the no-write code 63.
    if (state_q == COMMIT) retire_d = retire_cnt + 16'd1;

    unique case (state_q)
      IDLE, COMMIT: begin
        if (!transfer) begin
          state_d = IDLE;
        end else if (bus.in_is_load) begin
          state_d    = LOAD_WAIT;
          mem_req_d  = 1'b1;
          mem_addr_d = bus.in_addr;
          wait_d     = '0;
        end else begin
          state_d = COMMIT;
          c_d     = bus.in_dest;
          busc_d  = bus.in_result;
        end
      end
      LOAD_WAIT: begin
        // An ack on the last allowed cycle still commits: it is tested before the timeout.
        if (bus.mem_ack) begin
          state_d   = COMMIT;
          memory_d  = bus.mem_rdata;
          c_d       = DEST_LOAD;
          mem_req_d = 1'b0;
        end else if (wait_q == CW'(MEM_TIMEOUT - 1)) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_err_d = 1'b1;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      C          <= DEST_NONE;
      busC       <= '0;
      memory     <= '0;
      mem_err    <= 1'b0;
      retire_cnt <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      C          <= c_d;
      busC       <= busc_d;
      memory     <= memory_d;
      mem_err    <= mem_err_d;
      retire_cnt <= retire_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      wait_q     <= wait_d;
    end
  end

endmodule

// File: tb/tb_ev22_writeback_stage.sv
// Self-checking bench for ev22_writeback_stage: directed stimulus, commit scoreboard
// drained by an independent negedge monitor, plus direct checks of handshake/timing.
module tb_ev22_writeback_stage;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [5:0]    c;
  logic [DW-1:0] bus_c;
  logic [DW-1:0] memory;
  logic          mem_err;
  logic [15:0]   retire_cnt;

  always #5 clk = ~clk;

  ev22_writeback_stage_if #(.DW(DW), .AW(AW)) bus ();

  ev22_writeback_stage #(.DW(DW), .AW(AW), .MEM_TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .C          (c),
    .busC       (bus_c),
    .memory     (memory),
    .mem_err    (mem_err),
    .retire_cnt (retire_cnt)
  );

  typedef struct {
    logic [5:0]  c;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   err_pending = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_commit(input logic [5:0] dest, input logic [15:0] data);
    exp_t e;
    e.c    = dest;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic [5:0] dest, input logic [15:0] res);
    bus.in_valid   = 1'b1;
    bus.in_is_load = 1'b0;
    bus.in_dest    = dest;
    bus.in_result  = res;
  endtask

  task automatic drive_load(input logic [15:0] addr);
    bus.in_valid   = 1'b1;
    bus.in_is_load = 1'b1;
    bus.in_dest    = 6'd0;
    bus.in_addr    = addr;
  endtask

  task automatic idle();
    bus.in_valid   = 1'b0;
    bus.in_is_load = 1'b0;
  endtask

  // Monitor: any non-idle C is a retirement that must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (mem_err === 1'b1) begin
        check("mem_err_expected", err_pending, 1);
        err_pending = 0;
      end
      if (c !== 6'd63) begin
        if (sb.size() == 0) begin
          check("unexpected_commit", c, 6'd63);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("commit_c", c, e.c);
          if (e.c == 6'd62) check("commit_memory", memory, e.data);
          else              check("commit_busC", bus_c, e.data);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_is_load = 1'b0;
    bus.in_dest   = 6'd0;
    bus.in_result = '0;
    bus.in_addr   = '0;
    bus.mem_rdata = '0;
    bus.mem_ack   = 1'b0;

    // Reset values
    #7;
    check("rst_C", c, 6'd63);
    check("rst_busC", bus_c, 16'h0);
    check("rst_memory", memory, 16'h0);
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 16'h0);
    check("rst_mem_err", mem_err, 1'b0);
    check("rst_retire", retire_cnt, 16'h0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    #1 rst_n = 1'b1;
    tick();

    // 1: asynchronous reset in the middle of a load wait
    drive_alu(6'd7, 16'h1234);
    expect_commit(6'd7, 16'h1234);
    tick();
    drive_load(16'h0123);
    tick();
    idle();
    check("t1_mem_req", bus.mem_req, 1'b1);
    check("t1_mem_addr", bus.mem_addr, 16'h0123);
    check("t1_retire_before", retire_cnt, 16'd1);
    check("t1_in_ready_wait", bus.in_ready, 1'b0);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("t1_async_C", c, 6'd63);
    check("t1_async_mem_req", bus.mem_req, 1'b0);
    check("t1_async_mem_addr", bus.mem_addr, 16'h0);
    check("t1_async_retire", retire_cnt, 16'h0);
    check("t1_async_busC", bus_c, 16'h0);
    check("t1_async_in_ready", bus.in_ready, 1'b1);
    #3 rst_n = 1'b1;
    tick();

    // 2: back-to-back ALU results, then a no-write retirement
    drive_alu(6'd5, 16'h1111);
    expect_commit(6'd5, 16'h1111);
    check("t2_ready0", bus.in_ready, 1'b1);
    tick();
    drive_alu(6'd12, 16'h2222);
    expect_commit(6'd12, 16'h2222);
    check("t2_ready1", bus.in_ready, 1'b1);
    check("t2_C0", c, 6'd5);
    tick();
    drive_alu(6'd61, 16'hBEEF);
    expect_commit(6'd61, 16'hBEEF);
    check("t2_ready2", bus.in_ready, 1'b1);
    check("t2_C1", c, 6'd12);
    tick();
    idle();
    check("t2_C2", c, 6'd61);
    tick();
    check("t2_retire", retire_cnt, 16'd3);
    check("t2_idle_C", c, 6'd63);
    check("t2_busC_hold", bus_c, 16'hBEEF);
    drive_alu(6'd63, 16'h7777);
    tick();
    idle();
    check("t2_nowrite_C", c, 6'd63);
    check("t2_nowrite_busC", bus_c, 16'h7777);
    tick();
    check("t2_nowrite_retire", retire_cnt, 16'd4);

    // 3: load acknowledged after four wait cycles
    drive_load(16'h0040);
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      check("t3_mem_req", bus.mem_req, 1'b1);
      check("t3_mem_addr", bus.mem_addr, 16'h0040);
      check("t3_in_ready", bus.in_ready, 1'b0);
      check("t3_wait_C", c, 6'd63);
      if (i == 3) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'hA5A5;
        expect_commit(6'd62, 16'hA5A5);
      end
      tick();
    end
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'h0000;
    check("t3_C", c, 6'd62);
    check("t3_memory", memory, 16'hA5A5);
    check("t3_mem_req_drop", bus.mem_req, 1'b0);
    check("t3_in_ready_back", bus.in_ready, 1'b1);
    tick();
    check("t3_C_after", c, 6'd63);
    check("t3_memory_hold", memory, 16'hA5A5);
    check("t3_busC_hold", bus_c, 16'h7777);
    check("t3_retire", retire_cnt, 16'd5);

    // 4: load never acknowledged -> timeout after TO cycles
    drive_load(16'h0080);
    tick();
    idle();
    err_pending = 1;
    for (int i = 0; i < TO; i++) begin
      check("t4_mem_req", bus.mem_req, 1'b1);
      check("t4_mem_err_low", mem_err, 1'b0);
      check("t4_C", c, 6'd63);
      check("t4_in_ready", bus.in_ready, 1'b0);
      tick();
    end
    check("t4_mem_req_drop", bus.mem_req, 1'b0);
    check("t4_mem_err_pulse", mem_err, 1'b1);
    check("t4_C_end", c, 6'd63);
    check("t4_in_ready_back", bus.in_ready, 1'b1);
    check("t4_retire", retire_cnt, 16'd5);
    tick();
    check("t4_mem_err_once", mem_err, 1'b0);
    check("t4_retire_hold", retire_cnt, 16'd5);
    check("t4_memory_hold", memory, 16'hA5A5);

    // 5: ack arrives on the timeout cycle -> the load commits
    drive_load(16'h00C0);
    tick();
    idle();
    for (int i = 0; i < TO; i++) begin
      check("t5_mem_req", bus.mem_req, 1'b1);
      if (i == TO - 1) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'h5A5A;
        expect_commit(6'd62, 16'h5A5A);
      end
      tick();
    end
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'h0000;
    check("t5_C", c, 6'd62);
    check("t5_mem_err", mem_err, 1'b0);
    check("t5_memory", memory, 16'h5A5A);
    check("t5_mem_req_drop", bus.mem_req, 1'b0);
    tick();
    check("t5_mem_err_after", mem_err, 1'b0);
    check("t5_retire", retire_cnt, 16'd6);

    // 6: retire counter wraps 0xFFFF -> 0
    rst_n = 1'b0;
    #1;
    check("t6_rst_retire", retire_cnt, 16'h0);
    #2 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 65535; i++) begin
      drive_alu(6'(i % 62), 16'(i));
      expect_commit(6'(i % 62), 16'(i));
      tick();
    end
    idle();
    tick();
    check("t6_retire_max", retire_cnt, 16'hFFFF);
    drive_alu(6'd9, 16'h0909);
    expect_commit(6'd9, 16'h0909);
    tick();
    idle();
    tick();
    check("t6_retire_wrap", retire_cnt, 16'h0000);

    tick();
    check("sb_drained", sb.size(), 0);
    check("err_seen", err_pending, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
